// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encodings and port indices for the BRAM port arbiter.
package bram_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;
endpackage

// File: rtl/bram_port_arbiter_ram.sv
// BlockRam: single-port RAM with one-cycle registered read (read-before-write).
module BlockRam #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one single-port BlockRam between two
// masters, with a one-entry hold buffer on the read response path.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata
);
  state_t                state_q, state_d;
  logic                  last_q, last_d, owner_q, owner_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, ram_dout, ram_din, rsp_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  owner_rdy, can_acc, grant, accept, gnt_we;

  BlockRam #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk (clk),
    .we  (accept && gnt_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(ram_dout)
  );

  // A new access may only start once any pending response is being consumed this cycle.
  always_comb begin
    owner_rdy    = owner_q ? m1_rsp_ready : m0_rsp_ready;
    can_acc      = !rst && (state_q == ST_IDLE || owner_rdy);
    grant        = (m0_req_valid && m1_req_valid) ? ~last_q : m1_req_valid;
    accept       = can_acc && (m0_req_valid || m1_req_valid);
    gnt_we       = grant ? m1_req_we : m0_req_we;
    ram_addr     = grant ? m1_req_addr : m0_req_addr;
    ram_din      = grant ? m1_req_wdata : m0_req_wdata;
    m0_req_ready = can_acc && grant == PORT_M0;
    m1_req_ready = can_acc && grant == PORT_M1;
    last_d       = accept ? grant : last_q;
    owner_d      = (accept && !gnt_we) ? grant : owner_q;
    state_d      = (accept && !gnt_we) ? ST_RESP :
                   (state_q != ST_IDLE && !owner_rdy) ? ST_HOLD : ST_IDLE;
    hold_d       = (state_q == ST_RESP && !owner_rdy) ? ram_dout : hold_q;
    rsp_data     = (state_q == ST_HOLD) ? hold_q : ram_dout;
    m0_rsp_valid = state_q != ST_IDLE && owner_q == PORT_M0;
    m1_rsp_valid = state_q != ST_IDLE && owner_q == PORT_M1;
    m0_rsp_rdata = m0_rsp_valid ? rsp_data : '0;
    m1_rsp_rdata = m1_rsp_valid ? rsp_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= PORT_M1;
      owner_q <= PORT_M0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_bram_port_arbiter;
  logic        clk = 0, rst = 1;
  logic        m0_req_valid = 0, m0_req_we = 0, m0_rsp_ready = 1;
  logic        m1_req_valid = 0, m1_req_we = 0, m1_rsp_ready = 1;
  logic [9:0]  m0_req_addr = 0, m1_req_addr = 0;
  logic [31:0] m0_req_wdata = 0, m1_req_wdata = 0;
  logic        m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  int          checks = 0, failures = 0;

  bram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req_valid = 0; m1_req_valid = 0; m0_req_we = 0; m1_req_we = 0;
  endtask

  task automatic req(input int p, input logic we, input logic [9:0] a, input logic [31:0] d);
    if (p == 0) begin m0_req_valid = 1; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d; end
    else begin m1_req_valid = 1; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d; end
  endtask

  task automatic test_reset;
    rst = 1; req(0, 0, 0, 0); req(1, 0, 1, 0);
    for (int c = 0; c < 2; c++) begin
      tick; #1;
      checks++;
      if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid} !== 4'b0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: rdy=%b%b vld=%b%b required 0000", c, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid);
      end
    end
    tick; rst = 0; #1;
    checks++;
    if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata} !== {4'b1000, 64'd0}) begin
      failures++;
      $display("FAIL reset_first: rdy=%b%b vld=%b%b d0=%h d1=%h required rdy=10 vld=00 data 0", m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata);
    end
    idle_inputs;
  endtask

  task automatic test_write_then_read;
    tick; req(0, 1, 5, 32'hDEADBEEF); #1;
    tick; idle_inputs; req(1, 0, 5, 0); #1;
    checks++;
    if (m1_req_ready !== 1'b1) begin failures++; $display("FAIL wr_rd_accept: m1_req_ready=%b required 1", m1_req_ready); end
    tick; idle_inputs; #1;
    checks++;
    if ({m1_rsp_valid, m0_rsp_valid, m1_rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL wr_rd_data: v1=%b v0=%b d=%h required 1 0 deadbeef", m1_rsp_valid, m0_rsp_valid, m1_rsp_rdata);
    end
    tick;
  endtask

  task automatic test_round_robin;
    int idx [2];
    int g, pend_p, pend_a;
    for (int a = 0; a < 8; a++) begin req(0, 1, 10'(a), 32'(a * 3)); tick; end
    idle_inputs; req(1, 1, 8, 24); tick; idle_inputs;
    idx[0] = 0; idx[1] = 0; g = 0; pend_p = -1; pend_a = 0;
    for (int c = 0; c < 17; c++) begin
      if (c < 16) begin req(0, 0, 10'(idx[0]), 0); req(1, 0, 10'(idx[1]), 0); end
      else idle_inputs;
      #1;
      if (c < 16) begin
        checks++;
        if ({m0_req_ready, m1_req_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL rr_grant cyc%0d: rdy=%b%b required port %0d", c, m0_req_ready, m1_req_ready, g);
        end
      end
      if (pend_p >= 0) begin
        checks++;
        if ({m0_rsp_valid, m1_rsp_valid} !== ((pend_p == 0) ? 2'b10 : 2'b01) ||
            ((pend_p == 0) ? m0_rsp_rdata : m1_rsp_rdata) !== 32'(pend_a * 3)) begin
          failures++;
          $display("FAIL rr_rsp cyc%0d: vld=%b%b d0=%h d1=%h required port %0d data %h", c, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata, pend_p, pend_a * 3);
        end
      end
      pend_p = g; pend_a = idx[g]; idx[g]++; g = 1 - g;
      tick;
    end
    idle_inputs;
  endtask

  task automatic test_backpressure;
    req(0, 1, 3, 32'h11); tick; idle_inputs;
    m0_rsp_ready = 0; req(0, 0, 3, 0); tick; idle_inputs;
    req(1, 1, 3, 32'h22);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({m0_rsp_valid, m0_rsp_rdata, m0_req_ready, m1_req_ready} !== {1'b1, 32'h11, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold cyc%0d: vld=%b d=%h rdy=%b%b required 1 11 00", c, m0_rsp_valid, m0_rsp_rdata, m0_req_ready, m1_req_ready);
      end
      tick;
    end
    m0_rsp_ready = 1; #1;
    checks++;
    if ({m0_rsp_valid, m0_rsp_rdata, m1_req_ready} !== {1'b1, 32'h11, 1'b1}) begin
      failures++; $display("FAIL bp_release: vld=%b d=%h m1_rdy=%b required 1 11 1", m0_rsp_valid, m0_rsp_rdata, m1_req_ready);
    end
    tick; idle_inputs; #1;
    checks++;
    if (m0_rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_done: m0_rsp_valid=%b required 0", m0_rsp_valid); end
    req(0, 0, 3, 0); tick; idle_inputs; #1;
    checks++;
    if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'h22}) begin
      failures++; $display("FAIL bp_readback: vld=%b d=%h required 1 22", m0_rsp_valid, m0_rsp_rdata);
    end
    tick;
  endtask

  task automatic test_reset_midop;
    m1_rsp_ready = 0; req(1, 0, 4, 0); #1;
    checks++;
    if (m1_req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_accept: m1_req_ready=%b required 1", m1_req_ready); end
    tick; idle_inputs; rst = 1;
    tick; rst = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin
        failures++; $display("FAIL rst_mid_drop cyc%0d: vld=%b%b required 00", c, m0_rsp_valid, m1_rsp_valid);
      end
      tick;
    end
    m1_rsp_ready = 1; req(0, 0, 1, 0); req(1, 0, 2, 0); #1;
    checks++;
    if ({m0_req_ready, m1_req_ready} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_conflict: rdy=%b%b required 10", m0_req_ready, m1_req_ready);
    end
    idle_inputs; tick;
  endtask

  task automatic test_boundary;
    logic [31:0] v [2];
    for (int pat = 0; pat < 2; pat++) begin
      v[0] = pat ? 32'h0 : 32'hFFFFFFFF;
      v[1] = ~v[0];
      req(0, 1, 10'd0, v[0]); tick; idle_inputs;
      req(1, 1, 10'd1023, v[1]); tick; idle_inputs;
      for (int k = 0; k < 2; k++) begin
        req(k, 0, k ? 10'd1023 : 10'd0, 0); tick; idle_inputs; #1;
        checks++;
        if ((k ? {m1_rsp_valid, m1_rsp_rdata} : {m0_rsp_valid, m0_rsp_rdata}) !== {1'b1, v[k]}) begin
          failures++;
          $display("FAIL boundary pat%0d addr%0d: v0=%b d0=%h v1=%b d1=%h required %h", pat, k ? 1023 : 0, m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid, m1_rsp_rdata, v[k]);
        end
      end
      tick;
    end
  endtask

  // Transaction-level model: a pending response (port, data), a round-robin pointer and a word array.
  task automatic test_random;
    logic [31:0] mdl [16];
    logic        vld [2], we [2], rrdy [2];
    logic [3:0]  adr [2];
    logic [31:0] wd [2];
    logic        pend, pport, last, can, gp;
    logic [31:0] pdata;
    for (int a = 0; a < 16; a++) begin
      mdl[a] = $urandom; req(0, 1, 10'(a), mdl[a]); tick;
    end
    idle_inputs;
    pend = 0; pport = 0; pdata = 0; last = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        vld[p] = $urandom_range(0, 9) < 7; we[p] = $urandom_range(0, 9) < 3;
        adr[p] = 4'($urandom_range(0, 15)); wd[p] = $urandom; rrdy[p] = $urandom_range(0, 9) < 7;
      end
      m0_req_valid = vld[0]; m0_req_we = we[0]; m0_req_addr = 10'(adr[0]); m0_req_wdata = wd[0]; m0_rsp_ready = rrdy[0];
      m1_req_valid = vld[1]; m1_req_we = we[1]; m1_req_addr = 10'(adr[1]); m1_req_wdata = wd[1]; m1_rsp_ready = rrdy[1];
      #1;
      can = !pend || rrdy[pport];
      gp = (vld[0] && vld[1]) ? !last : vld[1];
      checks++;
      if ({m0_rsp_valid, m1_rsp_valid} !== {pend && !pport, pend && pport} ||
          m0_rsp_rdata !== ((pend && !pport) ? pdata : 32'd0) ||
          m1_rsp_rdata !== ((pend && pport) ? pdata : 32'd0)) begin
        failures++;
        $display("FAIL rand_rsp cyc%0d: vld=%b%b d0=%h d1=%h required pend=%b port=%0d data=%h", c, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata, pend, pport, pdata);
      end
      if (vld[0] || vld[1]) begin
        checks++;
        if ({m0_req_ready, m1_req_ready} !== {can && !gp, can && gp}) begin
          failures++;
          $display("FAIL rand_rdy cyc%0d: rdy=%b%b required %b%b", c, m0_req_ready, m1_req_ready, can && !gp, can && gp);
        end
      end
      if (pend && rrdy[pport]) pend = 0;
      if (can && (vld[0] || vld[1])) begin
        last = gp;
        if (we[gp]) mdl[adr[gp]] = wd[gp];
        else begin pend = 1; pport = gp; pdata = mdl[adr[gp]]; end
      end
      tick;
    end
    idle_inputs; m0_rsp_ready = 1; m1_rsp_ready = 1; tick; tick;
  endtask

  initial begin
    test_reset;
    test_write_then_read;
    test_round_robin;
    test_backpressure;
    test_reset_midop;
    test_boundary;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter that shares one single-port `BlockRam` between two masters, such as a core data port and a loader/DMA engine. It accepts at most one access per cycle with round-robin priority and gives write access to the shared RAM to one master at a time. It returns read data to the issuing master through a valid/ready response channel with a one-entry hold buffer. It sits between the masters and its own internal `BlockRam` instance.

## Interface
- `DATA_WIDTH`, 32, RAM word width.
- `ADDR_WIDTH`, 10, RAM address width; depth is 2**ADDR_WIDTH.

Ports (`N` is `0` or `1`):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `mN_req_valid`  in  1  request from master N.
- `mN_req_ready`  out  1  request accepted this cycle when valid&ready.
- `mN_req_we`  in  1  1 = write, 0 = read.
- `mN_req_addr`  in  ADDR_WIDTH  word address.
- `mN_req_wdata`  in  DATA_WIDTH  write data.
- `mN_rsp_valid`  out  1  read data available to master N.
- `mN_rsp_ready`  in  1  master N consumes the response.
- `mN_rsp_rdata`  out  DATA_WIDTH  read data; 0 whenever `mN_rsp_valid` is 0.

## Operation
- Accept at most one request per cycle across both masters. A write is fire-and-forget and gets no response. A read produces exactly one response, only to its issuer (`owner` register).
- Arbitration is round-robin:
  - `last` register holds the last granted port; it resets to 1, so master 0 wins the first conflict.
  - On conflict, grant the port != `last`. A single requester wins outright.
  - `last` updates only on an accept.
- The ready outputs are combinational from valids, `state`, `last` and the owner's `rsp_ready`. The ready of a non-granted port is 0.
- FSM `state`:
  - IDLE: no response pending. Can accept. An accepted read goes to RESP; an accepted write stays in IDLE.
  - RESP: the RAM output is valid. `rsp_valid`=1 to `owner`, with `rsp_rdata` taken directly from the RAM output.
    - Owner ready: the response completes and a new request may be accepted in the same cycle (next state RESP if read, IDLE otherwise).
    - Owner not ready: accept nothing, capture the RAM output into `hold_data`, go to HOLD.
  - HOLD: `rsp_valid`=1 with `rsp_rdata`=`hold_data`. Accept is allowed only in a cycle where the owner is ready, with the same next-state rule as RESP. Otherwise stay in HOLD, all readys 0.
- RAM drive:
  - `we` = accept & granted `req_we`.
  - addr/din come from the granted port.
  - With no accept, `we`=0 and the address is don't-care.
- Ordering: a write accepted in cycle t followed by a read of the same address accepted in t+1 (from either port) returns the new data.
- Address arithmetic: none. Addresses are used as-is over the full 0..2**ADDR_WIDTH-1 range.

## Timing
- Read latency is 1: a read accepted in cycle t produces `rsp_valid` in t+1.
- Sustained throughput is one access per cycle while responses are consumed immediately.
- Reset values while `rst`=1 and in the first cycle after reset:
  - all `req_ready` 0 during `rst`.
  - all `rsp_valid` 0.
  - all `rsp_rdata` 0.
  - `state`=IDLE, `last`=1, `hold_data`=0.
- Reset mid-operation: any in-flight or held response is dropped; no `rsp_valid` appears after reset. RAM contents are not cleared.
- Simultaneous response-consume and new accept in RESP/HOLD is legal and required. No bubble.

## Structure
- Shared package `bram_arb_pkg`:
  - state encodings `ST_IDLE`=2'd0, `ST_RESP`=2'd1, `ST_HOLD`=2'd2.
  - port index constants `PORT_M0`=0, `PORT_M1`=1.
- One sub-module: a `BlockRam` instance (`DATA_WIDTH`, `ADDR_WIDTH` passed through), 1-cycle registered read.
- The arbiter logic (grant, FSM, `owner`, `last`, `hold_data`) stays in this module.

## Test plan
- Reset: hold `rst` 2 cycles with both masters requesting reads → `req_ready` 0 and `rsp_valid` 0 throughout. In the first cycle after reset, m0 is granted.
- m0 writes 0xDEADBEEF to addr 5, then m1 reads addr 5 in the next cycle → `m1_rsp_valid`=1 one cycle after the accept with data 0xDEADBEEF; `m0_rsp_valid` stays 0.
- Both masters issue continuous reads of addrs 0..7 (preloaded with addr*3), both `rsp_ready`=1 → grants alternate m0, m1, m0, …; one response per cycle, each with correct data to the correct port.
- Backpressure: m0 reads addr 3 (holding 0x11) with `m0_rsp_ready`=0 for 3 cycles while m1 requests a write of 0x22 to addr 3:
  - `rsp_rdata` stays 0x11 and both `req_ready` stay 0.
  - In the cycle `m0_rsp_ready` rises, the response completes and m1's write is accepted in that same cycle.
  - A following read returns 0x22.
- Reset mid-op: m1 read accepted, `rst` asserted in the next cycle → `m1_rsp_valid` never asserts; after reset, the FSM is IDLE and m0 wins the first conflict.
- Boundary addresses: write/read addr 0 and addr 2**ADDR_WIDTH-1 with 0xFFFFFFFF and 0 → exact data returned with no aliasing between the two addresses.
